// File: rtl/timer0_unit_if.sv
// Byte-wide SFR bus between the datapath and an SFR-mapped peripheral.
//   sfr_wr    : write strobe, one cycle per write
//   sfr_addr  : SFR address for reads and writes
//   sfr_wdata : write data
//   sfr_rdata : combinational read data for sfr_addr (peripheral drives it)
// The master modport is the datapath side and the slave modport is the peripheral side.
interface timer0_unit_if;
  logic       sfr_wr;
  logic [7:0] sfr_addr;
  logic [7:0] sfr_wdata;
  logic [7:0] sfr_rdata;

  modport master (output sfr_wr, output sfr_addr, output sfr_wdata, input sfr_rdata);
  modport slave  (input sfr_wr, input sfr_addr, input sfr_wdata, output sfr_rdata);
endinterface

// File: rtl/timer0_unit.sv
// 8051-style Timer/Counter 0 in SFR space.
// Holds TMOD (low nibble), TCON (TF0/TR0), TL0 and TH0. It counts either
// prescaled clock ticks or falling edges on t0_pin. The modes are 13-bit,
// 16-bit and 8-bit auto-reload. Mode 3 freezes the count.
// Ports:
//   clock    : system clock, rising edge
//   reset    : synchronous, active-high
//   bus      : SFR bus (slave side), rdata is combinational
//   t0_pin   : external count input, asynchronous
//   int0_pin : external gate input, asynchronous, high enables counting when GATE=1
//   tf0_clr  : pulse from the control unit when the timer-0 vector is taken
//   tf0_irq  : interrupt request, equal to TF0
module timer0_unit #(
  parameter int PRESCALE = 12
) (
  input  logic         clock,
  input  logic         reset,
  timer0_unit_if.slave bus,
  input  logic         t0_pin,
  input  logic         int0_pin,
  input  logic         tf0_clr,
  output logic         tf0_irq
);

  localparam logic [7:0] ADDR_TCON = 8'h88;
  localparam logic [7:0] ADDR_TMOD = 8'h89;
  localparam logic [7:0] ADDR_TL0  = 8'h8A;
  localparam logic [7:0] ADDR_TH0  = 8'h8C;
  localparam logic [7:0] PRESC_MAX = 8'(PRESCALE - 1);

  logic [3:0] tmod_reg, tmod_next;
  logic       tr0_reg, tr0_next;
  logic       tf0_reg, tf0_next;
  logic [7:0] tl0_reg, tl0_next;
  logic [7:0] th0_reg, th0_next;
  logic [7:0] presc_reg, presc_next;
  logic       t0_meta_reg, t0_s_reg, t0_d_reg;
  logic       int0_meta_reg, int0_s_reg;

  logic       wr_tcon, wr_tmod, wr_tl0, wr_th0;
  logic       presc_tick, t0_fall, tick, run, step;
  logic       ovf, ovf_set;
  logic [7:0] tl0_inc, th0_inc;

  // TMOD fields
  logic       gate, c_t;
  logic [1:0] mode;
  assign gate = tmod_reg[3];
  assign c_t  = tmod_reg[2];
  assign mode = tmod_reg[1:0];

  assign wr_tcon = bus.sfr_wr && (bus.sfr_addr == ADDR_TCON);
  assign wr_tmod = bus.sfr_wr && (bus.sfr_addr == ADDR_TMOD);
  assign wr_tl0  = bus.sfr_wr && (bus.sfr_addr == ADDR_TL0);
  assign wr_th0  = bus.sfr_wr && (bus.sfr_addr == ADDR_TH0);

  // The prescaler runs freely and software writes never touch it.
  assign presc_tick = (presc_reg == PRESC_MAX);
  assign presc_next = presc_tick ? 8'd0 : presc_reg + 8'd1;

  // A falling edge means the previous synchronized sample was 1 and the current one is 0.
  assign t0_fall = t0_d_reg & ~t0_s_reg;
  assign tick    = c_t ? t0_fall : presc_tick;
  assign run     = tr0_reg & (~gate | int0_s_reg);
  assign step    = run & tick;

  // Increment candidates per mode. Mode 3 leaves the registers held with no overflow.
  always_comb begin
    tl0_inc = tl0_reg;
    th0_inc = th0_reg;
    ovf     = 1'b0;
    case (mode)
      2'd0: begin
        // 13-bit: TH0 holds the upper 8 bits and TL0[4:0] the lower 5. TL0[7:5] are held.
        {th0_inc, tl0_inc[4:0]} = {th0_reg, tl0_reg[4:0]} + 13'd1;
        ovf = (th0_reg == 8'hFF) && (tl0_reg[4:0] == 5'h1F);
      end
      2'd1: begin
        {th0_inc, tl0_inc} = {th0_reg, tl0_reg} + 16'd1;
        ovf = (th0_reg == 8'hFF) && (tl0_reg == 8'hFF);
      end
      2'd2: begin
        if (tl0_reg == 8'hFF) begin
          tl0_inc = th0_reg;
          ovf     = 1'b1;
        end else begin
          tl0_inc = tl0_reg + 8'd1;
        end
      end
      default: ;
    endcase
  end

  // A write to either count byte takes priority over the increment. It also suppresses the overflow.
  always_comb begin
    tl0_next = tl0_reg;
    th0_next = th0_reg;
    ovf_set  = 1'b0;
    if (wr_tl0) begin
      tl0_next = bus.sfr_wdata;
    end else if (wr_th0) begin
      th0_next = bus.sfr_wdata;
    end else if (step) begin
      tl0_next = tl0_inc;
      th0_next = th0_inc;
      ovf_set  = ovf;
    end
  end

  // An overflow set wins over every clear source in the same cycle.
  always_comb begin
    tmod_next = wr_tmod ? bus.sfr_wdata[3:0] : tmod_reg;
    tr0_next  = wr_tcon ? bus.sfr_wdata[4]   : tr0_reg;
    tf0_next  = tf0_reg;
    if (ovf_set)
      tf0_next = 1'b1;
    else if (wr_tcon)
      tf0_next = bus.sfr_wdata[5];
    else if (tf0_clr)
      tf0_next = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tmod_reg      <= 4'd0;
      tr0_reg       <= 1'b0;
      tf0_reg       <= 1'b0;
      tl0_reg       <= 8'h00;
      th0_reg       <= 8'h00;
      presc_reg     <= 8'd0;
      t0_meta_reg   <= 1'b0;
      t0_s_reg      <= 1'b0;
      t0_d_reg      <= 1'b0;
      int0_meta_reg <= 1'b0;
      int0_s_reg    <= 1'b0;
    end else begin
      tmod_reg      <= tmod_next;
      tr0_reg       <= tr0_next;
      tf0_reg       <= tf0_next;
      tl0_reg       <= tl0_next;
      th0_reg       <= th0_next;
      presc_reg     <= presc_next;
      t0_meta_reg   <= t0_pin;
      t0_s_reg      <= t0_meta_reg;
      t0_d_reg      <= t0_s_reg;
      int0_meta_reg <= int0_pin;
      int0_s_reg    <= int0_meta_reg;
    end
  end

  always_comb begin
    case (bus.sfr_addr)
      ADDR_TCON: bus.sfr_rdata = {2'b00, tf0_reg, tr0_reg, 4'b0000};
      ADDR_TMOD: bus.sfr_rdata = {4'b0000, tmod_reg};
      ADDR_TL0:  bus.sfr_rdata = tl0_reg;
      ADDR_TH0:  bus.sfr_rdata = th0_reg;
      default:   bus.sfr_rdata = 8'h00;
    endcase
  end

  assign tf0_irq = tf0_reg;

endmodule

// File: tb/tb_timer0_unit.sv
// Directed bench for timer0_unit. The main instance uses PRESCALE=1, so every
// cycle is a tick. A second instance uses PRESCALE=12 to check the tick rate.
// Expected values go into a scoreboard queue. They are popped and compared
// when the DUT output is sampled.
module tb_timer0_unit;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic t0_pin = 1'b0;
  logic int0_pin = 1'b0;
  logic tf0_clr = 1'b0;
  logic tf0_irq, tf0_irq12;

  timer0_unit_if bus ();
  timer0_unit_if bus12 ();

  timer0_unit #(.PRESCALE(1)) u_dut (
    .clock(clock), .reset(reset), .bus(bus), .t0_pin(t0_pin),
    .int0_pin(int0_pin), .tf0_clr(tf0_clr), .tf0_irq(tf0_irq)
  );

  timer0_unit #(.PRESCALE(12)) u_dut12 (
    .clock(clock), .reset(reset), .bus(bus12), .t0_pin(t0_pin),
    .int0_pin(int0_pin), .tf0_clr(tf0_clr), .tf0_irq(tf0_irq12)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  checks = 0;
  int  failures = 0;

  task automatic push_exp(input string tag, input logic [7:0] exp);
    sb_t item;
    item.tag = tag;
    item.exp = exp;
    sb_q.push_back(item);
  endtask

  task automatic sample(input logic [7:0] obs);
    sb_t item;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%02h expected=none", obs);
    end else begin
      item = sb_q.pop_front();
      assert (obs === item.exp) else begin
        failures++;
        $error("FAIL %s observed=%02h expected=%02h", item.tag, obs, item.exp);
      end
      $display("check %s observed=%02h expected=%02h", item.tag, obs, item.exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic sfr_write(input logic [7:0] addr, input logic [7:0] data);
    bus.sfr_wr    = 1'b1;
    bus.sfr_addr  = addr;
    bus.sfr_wdata = data;
    tick(1);
    bus.sfr_wr    = 1'b0;
  endtask

  task automatic read_check(input logic [7:0] addr, input logic [7:0] exp, input string tag);
    push_exp(tag, exp);
    bus.sfr_addr = addr;
    #1;
    sample(bus.sfr_rdata);
  endtask

  task automatic irq_check(input logic exp, input string tag);
    push_exp(tag, {7'b0, exp});
    #1;
    sample({7'b0, tf0_irq});
  endtask

  initial begin
    bus.sfr_wr = 1'b0; bus.sfr_addr = 8'h00; bus.sfr_wdata = 8'h00;
    bus12.sfr_wr = 1'b0; bus12.sfr_addr = 8'h00; bus12.sfr_wdata = 8'h00;
    tick(3);
    reset = 1'b0;

    // Reset state and SFR access
    read_check(8'h88, 8'h00, "rst_tcon");
    read_check(8'h89, 8'h00, "rst_tmod");
    read_check(8'h8A, 8'h00, "rst_tl0");
    read_check(8'h8C, 8'h00, "rst_th0");
    read_check(8'h90, 8'h00, "rst_unmapped");
    irq_check(1'b0, "rst_irq");
    sfr_write(8'h89, 8'hF5);
    read_check(8'h89, 8'h05, "tmod_mask");
    sfr_write(8'h88, 8'hFF);
    read_check(8'h88, 8'h30, "tcon_mask");
    sfr_write(8'h88, 8'h00);
    read_check(8'h8A, 8'h00, "tl0_idle");

    // Mode 1 overflow
    sfr_write(8'h8C, 8'hFF);
    sfr_write(8'h8A, 8'hFD);
    sfr_write(8'h89, 8'h01);
    sfr_write(8'h88, 8'h10);
    tick(3);
    read_check(8'h8A, 8'h00, "m1_tl0_wrap");
    read_check(8'h8C, 8'h00, "m1_th0_wrap");
    irq_check(1'b1, "m1_irq_set");
    tf0_clr = 1'b1;
    tick(1);
    tf0_clr = 1'b0;
    irq_check(1'b0, "m1_irq_clr");
    sfr_write(8'h88, 8'h00);

    // Mode 2 auto-reload
    sfr_write(8'h8C, 8'hF0);
    sfr_write(8'h8A, 8'hFE);
    sfr_write(8'h89, 8'h02);
    sfr_write(8'h88, 8'h10);
    read_check(8'h8A, 8'hFE, "m2_tl0_fe");
    tick(1);
    read_check(8'h8A, 8'hFF, "m2_tl0_ff");
    irq_check(1'b0, "m2_irq_pre");
    tick(1);
    read_check(8'h8A, 8'hF0, "m2_tl0_reload");
    read_check(8'h8C, 8'hF0, "m2_th0_hold");
    irq_check(1'b1, "m2_irq_set");
    sfr_write(8'h88, 8'h00);
    irq_check(1'b0, "tcon_wr_clr");

    // Mode 0 wrap
    sfr_write(8'h8C, 8'hFF);
    sfr_write(8'h8A, 8'hFF);
    sfr_write(8'h89, 8'h00);
    sfr_write(8'h88, 8'h10);
    tick(1);
    read_check(8'h8C, 8'h00, "m0_th0_wrap");
    read_check(8'h8A, 8'hE0, "m0_tl0_wrap");
    irq_check(1'b1, "m0_irq_set");
    sfr_write(8'h88, 8'h00);

    // Counter mode with GATE
    sfr_write(8'h8A, 8'h00);
    sfr_write(8'h8C, 8'h00);
    sfr_write(8'h89, 8'h0D);
    int0_pin = 1'b1;
    tick(3);
    sfr_write(8'h88, 8'h10);
    for (int i = 0; i < 5; i++) begin
      t0_pin = 1'b1; tick(3);
      t0_pin = 1'b0; tick(3);
    end
    tick(3);
    read_check(8'h8A, 8'h05, "ctr_5_edges");
    int0_pin = 1'b0;
    tick(3);
    for (int i = 0; i < 3; i++) begin
      t0_pin = 1'b1; tick(3);
      t0_pin = 1'b0; tick(3);
    end
    tick(3);
    read_check(8'h8A, 8'h05, "ctr_gated");
    read_check(8'h8C, 8'h00, "ctr_th0");
    sfr_write(8'h88, 8'h00);

    // Write to TL0 in the same cycle as a tick
    sfr_write(8'h89, 8'h01);
    sfr_write(8'h8C, 8'h00);
    sfr_write(8'h8A, 8'h00);
    sfr_write(8'h88, 8'h10);
    tick(2);
    sfr_write(8'h8A, 8'h10);
    read_check(8'h8A, 8'h10, "wr_beats_inc");
    tick(1);
    read_check(8'h8A, 8'h11, "inc_after_wr");

    // Overflow in the same cycle as tf0_clr
    sfr_write(8'h88, 8'h00);
    sfr_write(8'h8C, 8'hFF);
    sfr_write(8'h8A, 8'hFF);
    sfr_write(8'h88, 8'h10);
    tf0_clr = 1'b1;
    tick(1);
    tf0_clr = 1'b0;
    irq_check(1'b1, "ovf_beats_clr");
    read_check(8'h8A, 8'h00, "ovf_tl0");

    // Reset mid-count, then start the PRESCALE=12 instance from a known phase
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    bus12.sfr_wr = 1'b1; bus12.sfr_addr = 8'h88; bus12.sfr_wdata = 8'h10;
    tick(1);
    bus12.sfr_wr = 1'b0; bus12.sfr_addr = 8'h8A;
    read_check(8'h88, 8'h00, "mid_rst_tcon");
    read_check(8'h89, 8'h00, "mid_rst_tmod");
    read_check(8'h8A, 8'h00, "mid_rst_tl0");
    read_check(8'h8C, 8'h00, "mid_rst_th0");
    irq_check(1'b0, "mid_rst_irq");
    tick(10);
    read_check(8'h8A, 8'h00, "mid_rst_stopped");
    push_exp("p12_before", 8'h00);
    #1 sample(bus12.sfr_rdata);
    tick(1);
    push_exp("p12_first", 8'h01);
    #1 sample(bus12.sfr_rdata);
    tick(12);
    push_exp("p12_second", 8'h02);
    #1 sample(bus12.sfr_rdata);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer0_unit.md
# timer0_unit

8051-style Timer/Counter 0 peripheral in SFR space: the datapath reads and writes it over a byte-wide SFR bus, and the control unit consumes its overflow interrupt request. The block holds TMOD (low nibble), TCON (TF0/TR0), TL0 and TH0. It counts prescaled machine ticks or falling edges on an external pin in 13-bit, 16-bit or 8-bit auto-reload mode.

## Interface
- PRESCALE, 12, clock cycles per timer-mode tick; legal range is 1 to 255.
- clock  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high.
- sfr_wr  in  1  write strobe, one cycle per write.
- sfr_addr  in  8  SFR address for both reads and writes.
- sfr_wdata  in  8  write data.
- sfr_rdata  out  8  combinational read data for sfr_addr.
- t0_pin  in  1  external count input, asynchronous.
- int0_pin  in  1  external gate input, active-high for gating, asynchronous.
- tf0_clr  in  1  pulse from the control unit when the timer-0 vector is taken.
- tf0_irq  out  1  interrupt request, equal to TF0.

## Operation
- Address map:
  - TCON = 0x88: bit 5 = TF0, bit 4 = TR0; other bits are ignored on write and read as 0.
  - TMOD = 0x89: bits [3:0] = GATE, C/T, M1, M0; bits [7:4] are ignored on write and read as 0.
  - TL0 = 0x8A.
  - TH0 = 0x8C.
  - Unmapped addresses read 0x00.
- Count enable: run = TR0 & (~GATE | int0_s).
- Input sync: t0_pin and int0_pin each pass through two flops (t0_s, int0_s). A third flop on t0_s provides edge detection.
- Count source:
  - C/T=0 (timer): a free-running prescaler 0..PRESCALE-1 produces tick when it equals PRESCALE-1. It is never reset by writes.
  - C/T=1 (counter): tick is a detected falling edge of t0_s.
- On each cycle with run & tick, the timer increments according to M1:M0.
  - Mode 0 (13-bit): TL0[4:0] increments and carries into TH0. TL0[7:5] are held. When TH0 = 0xFF and TL0[4:0] = 0x1F, TH0 and TL0[4:0] wrap to 0 and the step is an overflow.
  - Mode 1 (16-bit): {TH0,TL0} increments. The step from 0xFFFF to 0x0000 is an overflow.
  - Mode 2 (8-bit auto-reload): TL0 increments. When TL0 = 0xFF it loads TL0 <= TH0 instead, and the step is an overflow. TH0 is unchanged.
  - Mode 3: counting is frozen. Registers hold, and no overflow occurs.
- An overflow sets TF0.
- TF0 is cleared by tf0_clr or by a TCON write with bit 5 = 0. A TCON write with bit 5 = 1 sets TF0.
- Priority:
  - Overflow set beats any clear in the same cycle.
  - An SFR write to TL0 or TH0 beats the increment in the same cycle. In that cycle the written byte takes the write data, the other byte is held, and no overflow is raised.
- Writing TMOD changes the mode starting from the next tick; register contents are kept.

## Timing
- Reset values: TMOD = 0, TR0 = 0, TF0 = 0, TL0 = 0x00, TH0 = 0x00, prescaler = 0, sync/edge flops = 0. Consequently tf0_irq = 0 and sfr_rdata = 0x00 for unmapped addresses.
- Reset asserted mid-count clears everything on that edge. Counting resumes only after software sets TR0 again.
- SFR writes take effect at the clock edge with sfr_wr = 1. A read in the following cycle returns the new value.
- Increment latency: the counter changes at the edge ending the run & tick cycle.
- Overflow: TF0 and tf0_irq go high at the same edge as the wrap, and are visible the cycle after.
- Counter mode: a falling edge on t0_pin is counted 3 cycles later (2 sync flops plus 1 edge flop). The pin must hold each level for at least 2 clock cycles to be counted. Each edge is counted at most once.
- GATE path: int0_pin affects run after a 2-cycle synchronizer delay.
- Timer mode, PRESCALE = 12: with TR0 = 1, the timer counts exactly once every 12 clocks.

## Test plan
- Reset and SFR access:
  - Assert reset, then read 0x88, 0x89, 0x8A, 0x8C and 0x90 -> all 0x00.
  - Write TMOD = 0xF5 -> reads back 0x05.
  - Write TCON = 0xFF -> reads back 0x30.
- Mode 1 overflow (PRESCALE = 1):
  - Setup: TH0 = 0xFF, TL0 = 0xFD, TMOD = 0x01, TR0 = 1.
  - Expected: after 3 counting cycles TH0:TL0 = 0x0000 and tf0_irq = 1.
  - Then pulse tf0_clr -> tf0_irq = 0 on the next cycle.
- Mode 2 auto-reload:
  - Setup: TH0 = 0xF0, TL0 = 0xFE, mode 2, TR0 = 1, PRESCALE = 1.
  - Expected: TL0 steps 0xFE -> 0xFF -> 0xF0, TF0 is set at the reload, TH0 stays 0xF0.
- Mode 0 wrap:
  - Setup: TH0 = 0xFF, TL0 = 0xFF.
  - Expected: after 1 tick TH0 = 0x00, TL0 = 0xE0, TF0 = 1.
- Counter mode with GATE:
  - Setup: TMOD = 0x0D.
  - Apply 5 falling edges on t0_pin while int0_pin = 1 -> TL0 = 5.
  - Apply 3 more edges with int0_pin = 0 -> TL0 stays 5.
- Collisions:
  - Write TL0 = 0x10 in the same cycle as a tick -> TL0 = 0x10 (no increment).
  - Overflow in the same cycle as tf0_clr -> TF0 = 1.
  - Assert reset mid-count -> all registers return to 0 and counting stops.
